axis_sync_packet_fifo: RTL and testbench

Single-clock, parametrised AXI-Stream FIFO for buffering pixel/frame and DDR command traffic inside one clock domain. It generalises our DDR-side stream FIFO with runtime-visible occupancy and an optional packet (store-and-forward) mode. It also adds a jumbo-packet fallback so that an oversize packet can never deadlock the stream.

---
 rtl/axis_sync_packet_fifo.sv | 148 ++++++++++++++
 tb/tb_axis_sync_packet_fifo.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_packet_fifo.sv
// Single-clock AXI-Stream FIFO with first-word-fall-through output, occupancy
// flags, an optional store-and-forward packet mode, and a jumbo fallback so a
// packet larger than the storage still drains instead of deadlocking.
module axis_sync_packet_fifo #(
    parameter int BIT_WIDTH         = 128,
    parameter int DEPTH             = 128,
    parameter int PROG_FULL_THRESH  = 116,
    parameter int PROG_EMPTY_THRESH = 10,
    parameter int PACKET_MODE       = 0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [BIT_WIDTH-1:0]         s_axis_tdata,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [BIT_WIDTH-1:0]         m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         prog_full,
    output logic                         prog_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [$clog2(DEPTH):0]       pkt_count,
    output logic                         jumbo
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] PF_CNT   = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_CNT   = CW'(PROG_EMPTY_THRESH);

    typedef enum logic {
        ST_NORMAL,
        ST_JUMBO
    } state_t;

    logic [BIT_WIDTH:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_pkt_count;
    logic               r_ready_en;
    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_full;
    logic               w_not_empty;
    logic               w_wr;
    logic               w_rd;
    logic               w_wr_last;
    logic               w_rd_last;
    logic               w_jumbo;
    logic               w_valid;
    logic [BIT_WIDTH:0] w_head;

    // Head of queue is read combinationally so the output falls through.
    assign w_head      = r_mem[r_rptr];
    assign w_full      = (r_count == FULL_CNT);
    assign w_not_empty = (r_count != '0);

    assign s_axis_tready = r_ready_en & ~w_full;
    assign w_wr          = s_axis_tvalid & s_axis_tready;
    assign w_rd          = w_valid & m_axis_tready;
    assign w_wr_last     = w_wr & s_axis_tlast;
    assign w_rd_last     = w_rd & w_head[BIT_WIDTH];

    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_head[BIT_WIDTH-1:0];
    assign m_axis_tlast  = w_valid & w_head[BIT_WIDTH];
    assign prog_full     = (r_count >= PF_CNT);
    assign prog_empty    = (r_count <= PE_CNT);
    assign count         = r_count;
    assign pkt_count     = r_pkt_count;
    assign jumbo         = w_jumbo;

    // Storage write: data plus tlast, no reset needed on the array.
    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Pointers, occupancy and packet counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
            r_ready_en  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_wr_last, w_rd_last})
                2'b10:   r_pkt_count <= r_pkt_count + CW'(1);
                2'b01:   r_pkt_count <= r_pkt_count - CW'(1);
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    // Jumbo FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Jumbo FSM next state: full with no complete packet means one oversize
    // packet owns the storage, so switch to cut-through until its tlast leaves.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: begin
                if ((PACKET_MODE != 0) && w_full && (r_pkt_count == '0)) begin
                    w_state_nxt = ST_JUMBO;
                end
            end
            ST_JUMBO: begin
                if (w_rd_last) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    // Jumbo FSM outputs: jumbo flag and output-valid gating.
    always_comb begin
        w_jumbo = 1'b0;
        w_valid = w_not_empty;
        if (PACKET_MODE != 0) begin
            w_jumbo = (r_state == ST_JUMBO);
            w_valid = w_not_empty & ((r_pkt_count != '0) | w_jumbo);
        end
    end

endmodule

// File: tb/tb_axis_sync_packet_fifo.sv
// Directed bench for axis_sync_packet_fifo: one cut-through instance and one
// store-and-forward instance, both 8 deep with thresholds 6/2.
module tb_axis_sync_packet_fifo;

    localparam int BW = 8;

    logic           aclk;
    logic           aresetn;

    logic           s0_tvalid, s0_tready, s0_tlast;
    logic [BW-1:0]  s0_tdata;
    logic           m0_tvalid, m0_tready, m0_tlast;
    logic [BW-1:0]  m0_tdata;
    logic           pf0, pe0, jmb0;
    logic [3:0]     cnt0, pkt0;

    logic           s1_tvalid, s1_tready, s1_tlast;
    logic [BW-1:0]  s1_tdata;
    logic           m1_tvalid, m1_tready, m1_tlast;
    logic [BW-1:0]  m1_tdata;
    logic           pf1, pe1, jmb1;
    logic [3:0]     cnt1, pkt1;

    int checks   = 0;
    int failures = 0;

    axis_sync_packet_fifo #(
        .BIT_WIDTH(BW), .DEPTH(8), .PROG_FULL_THRESH(6),
        .PROG_EMPTY_THRESH(2), .PACKET_MODE(0)
    ) u0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
        .s_axis_tdata(s0_tdata), .s_axis_tlast(s0_tlast),
        .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
        .m_axis_tdata(m0_tdata), .m_axis_tlast(m0_tlast),
        .prog_full(pf0), .prog_empty(pe0), .count(cnt0),
        .pkt_count(pkt0), .jumbo(jmb0)
    );

    axis_sync_packet_fifo #(
        .BIT_WIDTH(BW), .DEPTH(8), .PROG_FULL_THRESH(6),
        .PROG_EMPTY_THRESH(2), .PACKET_MODE(1)
    ) u1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
        .s_axis_tdata(s1_tdata), .s_axis_tlast(s1_tlast),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tlast(m1_tlast),
        .prog_full(pf1), .prog_empty(pe1), .count(cnt1),
        .pkt_count(pkt1), .jumbo(jmb1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        aresetn   = 1'b0;
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0; m0_tready = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0; m1_tready = 1'b0;
        tick(); tick();
        checks++;
        if ({cnt0, pkt0, jmb0, m0_tvalid, m0_tlast, pf0, pe0, s0_tready} !== 14'b0000_0000_0000_10) begin
            failures++;
            $display("FAIL reset_u0 got=%b exp=%b",
                     {cnt0, pkt0, jmb0, m0_tvalid, m0_tlast, pf0, pe0, s0_tready}, 14'b0000_0000_0000_10);
        end
        checks++;
        if ({cnt1, pkt1, jmb1, m1_tvalid, m1_tlast, pf1, pe1, s1_tready} !== 14'b0000_0000_0000_10) begin
            failures++;
            $display("FAIL reset_u1 got=%b exp=%b",
                     {cnt1, pkt1, jmb1, m1_tvalid, m1_tlast, pf1, pe1, s1_tready}, 14'b0000_0000_0000_10);
        end
        aresetn = 1'b1;
        checks++;
        if (s0_tready !== 1'b0) begin
            failures++;
            $display("FAIL tready_before_edge got=%b exp=0", s0_tready);
        end
        tick();
        checks++;
        if (s0_tready !== 1'b1 || s1_tready !== 1'b1) begin
            failures++;
            $display("FAIL tready_after_release got=%b%b exp=11", s0_tready, s1_tready);
        end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (s0_tready !== 1'b1) begin
                failures++;
                $display("FAIL fill_tready[%0d] got=%b exp=1", i, s0_tready);
            end
            s0_tvalid = 1'b1; s0_tdata = BW'(i); s0_tlast = 1'b0;
            tick();
            checks++;
            if (cnt0 !== 4'(i + 1) || pf0 !== (i + 1 >= 6) || pe0 !== (i + 1 <= 2)) begin
                failures++;
                $display("FAIL fill_count[%0d] got cnt=%0d pf=%b pe=%b exp cnt=%0d pf=%b pe=%b",
                         i, cnt0, pf0, pe0, i + 1, (i + 1 >= 6), (i + 1 <= 2));
            end
        end
        checks++;
        if (s0_tready !== 1'b0) begin
            failures++;
            $display("FAIL full_tready got=%b exp=0", s0_tready);
        end
        s0_tdata = 8'hEE;
        tick();
        checks++;
        if (cnt0 !== 4'd8 || m0_tdata !== 8'h00) begin
            failures++;
            $display("FAIL write_at_full got cnt=%0d head=%h exp cnt=8 head=00", cnt0, m0_tdata);
        end
        s0_tvalid = 1'b0;
        m0_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== BW'(i)) begin
                failures++;
                $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, m0_tvalid, m0_tdata, BW'(i));
            end
            tick();
        end
        checks++;
        if (m0_tvalid !== 1'b0 || cnt0 !== 4'd0) begin
            failures++;
            $display("FAIL drain_empty got v=%b cnt=%0d exp v=0 cnt=0", m0_tvalid, cnt0);
        end
        m0_tready = 1'b0;
    endtask

    task automatic test_back_to_back;
        m0_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s0_tvalid = 1'b1; s0_tdata = BW'(8'h40 + k); s0_tlast = 1'b0;
            tick();
            checks++;
            if (cnt0 !== 4'd1 || m0_tvalid !== 1'b1 || m0_tdata !== BW'(8'h40 + k)) begin
                failures++;
                $display("FAIL stream[%0d] got cnt=%0d v=%b d=%h exp cnt=1 v=1 d=%h",
                         k, cnt0, m0_tvalid, m0_tdata, BW'(8'h40 + k));
            end
        end
        s0_tvalid = 1'b0;
        m0_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== 8'h53) begin
                failures++;
                $display("FAIL hold[%0d] got v=%b d=%h exp v=1 d=53", k, m0_tvalid, m0_tdata);
            end
        end
        m0_tready = 1'b1;
        tick();
        checks++;
        if (cnt0 !== 4'd0 || m0_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL stream_empty got cnt=%0d v=%b exp cnt=0 v=0", cnt0, m0_tvalid);
        end
        m0_tready = 1'b0;
    endtask

    task automatic test_store_forward;
        m1_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s1_tvalid = 1'b1; s1_tdata = BW'(8'hA0 + i); s1_tlast = (i == 3);
            tick();
            if (i < 3) begin
                checks++;
                if (m1_tvalid !== 1'b0 || pkt1 !== 4'd0) begin
                    failures++;
                    $display("FAIL sf_hold[%0d] got v=%b pkt=%0d exp v=0 pkt=0", i, m1_tvalid, pkt1);
                end
            end
        end
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        checks++;
        if (m1_tvalid !== 1'b1 || pkt1 !== 4'd1 || cnt1 !== 4'd4) begin
            failures++;
            $display("FAIL sf_release got v=%b pkt=%0d cnt=%0d exp v=1 pkt=1 cnt=4", m1_tvalid, pkt1, cnt1);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (m1_tvalid !== 1'b1 || m1_tdata !== BW'(8'hA0 + j) || m1_tlast !== (j == 3)) begin
                failures++;
                $display("FAIL sf_read[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         j, m1_tvalid, m1_tdata, m1_tlast, BW'(8'hA0 + j), (j == 3));
            end
            tick();
        end
        checks++;
        if (pkt1 !== 4'd0 || cnt1 !== 4'd0 || m1_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL sf_done got pkt=%0d cnt=%0d v=%b exp 0 0 0", pkt1, cnt1, m1_tvalid);
        end
        m1_tready = 1'b0;
    endtask

    task automatic test_jumbo;
        int wi;
        int ri;
        logic do_w;
        logic do_r;
        logic last_rd;
        m1_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s1_tvalid = 1'b1; s1_tdata = BW'(8'hB0 + i); s1_tlast = 1'b0;
            tick();
            checks++;
            if (jmb1 !== 1'b0 || m1_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL jumbo_pre[%0d] got j=%b v=%b exp j=0 v=0", i, jmb1, m1_tvalid);
            end
        end
        s1_tdata = 8'hB8;
        tick();
        checks++;
        if (jmb1 !== 1'b1 || m1_tvalid !== 1'b1 || m1_tdata !== 8'hB0 || cnt1 !== 4'd8) begin
            failures++;
            $display("FAIL jumbo_enter got j=%b v=%b d=%h cnt=%0d exp j=1 v=1 d=b0 cnt=8",
                     jmb1, m1_tvalid, m1_tdata, cnt1);
        end
        wi = 8;
        ri = 0;
        for (int c = 0; c < 40 && ri < 12; c++) begin
            s1_tvalid = (wi < 12);
            s1_tdata  = BW'(8'hB0 + wi);
            s1_tlast  = (wi == 11);
            m1_tready = 1'b1;
            do_w    = s1_tvalid & s1_tready;
            do_r    = m1_tvalid;
            last_rd = 1'b0;
            if (do_r) begin
                checks++;
                if (m1_tdata !== BW'(8'hB0 + ri) || m1_tlast !== (ri == 11)) begin
                    failures++;
                    $display("FAIL jumbo_read[%0d] got d=%h l=%b exp d=%h l=%b",
                             ri, m1_tdata, m1_tlast, BW'(8'hB0 + ri), (ri == 11));
                end
                last_rd = (ri == 11);
                ri++;
            end
            if (do_w) wi++;
            tick();
            if (last_rd) begin
                checks++;
                if (jmb1 !== 1'b0) begin
                    failures++;
                    $display("FAIL jumbo_exit got j=%b exp 0", jmb1);
                end
            end
        end
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        checks++;
        if (ri !== 12 || cnt1 !== 4'd0 || pkt1 !== 4'd0) begin
            failures++;
            $display("FAIL jumbo_drain got reads=%0d cnt=%0d pkt=%0d exp 12 0 0", ri, cnt1, pkt1);
        end
        m1_tready = 1'b0;
    endtask

    task automatic test_simul_tlast;
        m1_tready = 1'b0;
        s1_tvalid = 1'b1; s1_tdata = 8'hC0; s1_tlast = 1'b1;
        tick();
        checks++;
        if (pkt1 !== 4'd1 || m1_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL simul_setup got pkt=%0d v=%b exp pkt=1 v=1", pkt1, m1_tvalid);
        end
        s1_tdata = 8'hC1; m1_tready = 1'b1;
        tick();
        checks++;
        if (pkt1 !== 4'd1 || cnt1 !== 4'd1 || m1_tvalid !== 1'b1 || m1_tdata !== 8'hC1) begin
            failures++;
            $display("FAIL simul_tlast got pkt=%0d cnt=%0d v=%b d=%h exp pkt=1 cnt=1 v=1 d=c1",
                     pkt1, cnt1, m1_tvalid, m1_tdata);
        end
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        tick();
        checks++;
        if (pkt1 !== 4'd0 || cnt1 !== 4'd0) begin
            failures++;
            $display("FAIL simul_drain got pkt=%0d cnt=%0d exp 0 0", pkt1, cnt1);
        end
        m1_tready = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) begin
            s1_tvalid = 1'b1; s1_tdata = BW'(8'hD0 + i); s1_tlast = 1'b0;
            tick();
        end
        s1_tvalid = 1'b0;
        checks++;
        if (cnt1 !== 4'd5 || prog_empty_bad()) begin
            failures++;
            $display("FAIL partial_fill got cnt=%0d pe=%b exp cnt=5 pe=0", cnt1, pe1);
        end
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({cnt1, pkt1, jmb1, m1_tvalid, m1_tlast, pf1, pe1, s1_tready} !== 14'b0000_0000_0000_10) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b",
                     {cnt1, pkt1, jmb1, m1_tvalid, m1_tlast, pf1, pe1, s1_tready}, 14'b0000_0000_0000_10);
        end
        tick(); tick();
        aresetn = 1'b1;
        tick();
        s1_tvalid = 1'b1; s1_tdata = 8'hE0; s1_tlast = 1'b0;
        tick();
        checks++;
        if (m1_tvalid !== 1'b0 || cnt1 !== 4'd1) begin
            failures++;
            $display("FAIL fresh_first got v=%b cnt=%0d exp v=0 cnt=1", m1_tvalid, cnt1);
        end
        s1_tdata = 8'hE1; s1_tlast = 1'b1;
        tick();
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        m1_tready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (m1_tvalid !== 1'b1 || m1_tdata !== BW'(8'hE0 + j) || m1_tlast !== (j == 1)) begin
                failures++;
                $display("FAIL fresh_read[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         j, m1_tvalid, m1_tdata, m1_tlast, BW'(8'hE0 + j), (j == 1));
            end
            tick();
        end
        checks++;
        if (cnt1 !== 4'd0 || pkt1 !== 4'd0 || m1_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL fresh_done got cnt=%0d pkt=%0d v=%b exp 0 0 0", cnt1, pkt1, m1_tvalid);
        end
        m1_tready = 1'b0;
    endtask

    function automatic logic prog_empty_bad();
        return (pe1 !== 1'b0);
    endfunction

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_store_forward();
        test_jumbo();
        test_simul_tlast();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
